fetch_unit: RTL

Instruction-fetch stage for the ARM (LEGv8-subset) CPU. Holds the program counter, drives the byte address into the combinational instruction ROM, and registers the returned instruction with its PC into an IF/ID register for the decoder. Handles stall, flush, downstream branch redirect, optional fetch-time resolution of unconditional `B`, and a sticky fault for out-of-range or misaligned fetches.

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_next_pc.sv | 42 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage types, opcodes and the B offset helper
package fetch_unit_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [31:0] INSTR_NOP = 32'h0;

  // imm26 is a word offset: sign-extend, then scale to bytes
  function automatic logic [63:0] b_offset(input logic [25:0] imm26);
    return {{36{imm26[25]}}, imm26, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - next-PC selection and early-B target adder
// Early-B resolution is compiled in only when FETCH_EARLY_B_EN is defined.
module fetch_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [63:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        run_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [63:0] br_target_i,
  output logic [63:0] next_pc_o,
  output logic        early_b_o
);

`ifdef FETCH_EARLY_B_EN
  localparam logic EARLY_B_EN = 1'b1;
`else
  localparam logic EARLY_B_EN = 1'b0;
`endif

  logic        is_b;
  logic [63:0] b_target;

  assign is_b      = (instr_i[31:26] == OPC_B);
  assign b_target  = pc_i + b_offset(instr_i[25:0]);
  assign early_b_o = EARLY_B_EN && run_i && !stall_i && !br_taken_i && is_b;

  always_comb begin
    next_pc_o = pc_i + 64'd4;
    if (!run_i) begin
      next_pc_o = pc_i;
    end else if (br_taken_i) begin
      next_pc_o = br_target_i;
    end else if (stall_i) begin
      next_pc_o = pc_i;
    end else if (early_b_o) begin
      next_pc_o = b_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, fault FSM and IF/ID register
// Optional fetch-time B resolution is enabled by defining FETCH_EARLY_B_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_pred_taken,
  output logic        fault
);

  localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [63:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic         if_valid_q, if_valid_d;
  logic         if_pred_q, if_pred_d;

  logic oob, misalign, run, early_b;

  // Bounds check is done in 65 bits so a PC near 2^64 cannot wrap into range
  assign oob      = (state_q == RUN) && !stall &&
                    (({1'b0, pc_q} + 65'd3) >= IMEM_LIMIT);
  assign misalign = br_taken && (br_target[1:0] != 2'b00);
  assign run      = (state_q == RUN) && !oob && !misalign;

  fetch_next_pc u_next_pc (
    .pc_i        (pc_q),
    .instr_i     (imem_instr),
    .run_i       (run),
    .stall_i     (stall),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .next_pc_o   (pc_d),
    .early_b_o   (early_b)
  );

  always_comb begin
    state_d    = state_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if_pred_d  = if_pred_q;
    case (state_q)
      RUN: begin
        if (oob || misalign) begin
          state_d = FAULT;
        end
        if (br_taken || flush) begin
          if_valid_d = 1'b0;
          if_instr_d = INSTR_NOP;
          if_pred_d  = 1'b0;
        end else if (!stall) begin
          if (oob) begin
            if_valid_d = 1'b0;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_instr;
            if_valid_d = 1'b1;
            if_pred_d  = early_b;
          end
        end
      end
      FAULT: begin
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      if_pc_q    <= 64'h0;
      if_instr_q <= INSTR_NOP;
      if_valid_q <= 1'b0;
      if_pred_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      if_pred_q  <= if_pred_d;
    end
  end

  assign imem_addr     = pc_q;
  assign if_pc         = if_pc_q;
  assign if_instr      = if_instr_q;
  assign if_valid      = if_valid_q;
  assign if_pred_taken = if_pred_q;
  assign fault         = (state_q == FAULT);

endmodule
